// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped, read-only instruction cache.
package icache_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int WORD_W      = 32;
  localparam int PROC_ADDR_W = 30;
  localparam int MEM_ADDR_W  = 28;
  localparam int LINE_W      = 128;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: one combinational read port by index, one refill write port.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = MEM_ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  logic              valid_q [NUM_BLOCKS];
  logic [TAG_W-1:0]  tag_q   [NUM_BLOCKS];
  logic [LINE_W-1:0] data_q  [NUM_BLOCKS];

  // NOTE: the data array is reset along with valid/tag so a miss never drives X onto proc_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (wr_en_i) begin
      // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
      valid_q[wr_idx_i] <= 1'b1;
      tag_q[wr_idx_i]   <= wr_tag_i;
      data_q[wr_idx_i]  <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, blocking single-line refill.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   proc_read,
  input  logic                   proc_write,
  input  logic [PROC_ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0]      proc_wdata,
  output logic [WORD_W-1:0]      proc_rdata,
  output logic                   proc_stall,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_ready
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] miss_q, miss_d;

  logic [MEM_ADDR_W-1:0] req_line;
  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [1:0]            req_word;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_line;
  logic                  hit;
  logic                  fill_en;

  // The cache is read-only: write requests are accepted and dropped.
  logic unused_write;
  assign unused_write = ^{proc_write, proc_wdata};

  assign req_line = proc_addr[PROC_ADDR_W-1:2];
  assign req_idx  = req_line[IDX_W-1:0];
  assign req_tag  = req_line[MEM_ADDR_W-1:IDX_W];
  assign req_word = proc_addr[1:0];

  icache_line_store #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (fill_en),
    .wr_idx_i   (miss_q[IDX_W-1:0]),
    .wr_tag_i   (miss_q[MEM_ADDR_W-1:IDX_W]),
    .wr_line_i  (mem_rdata)
  );

  assign hit        = proc_read && rd_valid && (rd_tag == req_tag);
  assign proc_rdata = rd_line[{req_word, 5'b0} +: WORD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    miss_d     = miss_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    fill_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (proc_read && !hit) begin
          proc_stall = 1'b1;
          miss_d     = req_line;
          state_d    = S_REFILL;
        end
      end
      S_REFILL: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = miss_q;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: cache-level model checked every cycle plus directed literal checks.
module tb_icache;

  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata, proc_rdata;
  logic         proc_stall, mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  localparam logic [127:0] L1   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L9   = 128'h99999993_99999992_99999991_99999990;
  localparam logic [127:0] L4   = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] LC   = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
  localparam logic [127:0] LBAD = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

  icache #(.NUM_BLOCKS(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: which line address each set holds, its data, and whether a refill is outstanding.
  bit           m_valid [NB];
  logic [27:0]  m_line  [NB];
  logic [127:0] m_data  [NB];
  bit           m_refill;
  logic [27:0]  m_pend;

  function automatic bit m_hit(input logic [29:0] a);
    int s = int'(a[29:2] % NB);
    return m_valid[s] && (m_line[s] == a[29:2]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_refill <= 1'b0;
      m_pend   <= '0;
      for (int i = 0; i < NB; i++) begin
        m_valid[i] <= 1'b0;
        m_line[i]  <= '0;
        m_data[i]  <= '0;
      end
    end else if (!m_refill) begin
      if (proc_read && !m_hit(proc_addr)) begin
        m_refill <= 1'b1;
        m_pend   <= proc_addr[29:2];
      end
    end else if (mem_ready) begin
      m_valid[int'(m_pend % NB)] <= 1'b1;
      m_line[int'(m_pend % NB)]  <= m_pend;
      m_data[int'(m_pend % NB)]  <= mem_rdata;
      m_refill                   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin : cmp
      bit exp_hit;
      exp_hit = !m_refill && proc_read && m_hit(proc_addr);
      check("model_stall", proc_stall, m_refill || (proc_read && !exp_hit));
      check("model_mem_read", mem_read, m_refill);
      check("model_mem_write", mem_write, 1'b0);
      check("model_mem_wdata", mem_wdata, '0);
      check("model_rdata_known", $isunknown(proc_rdata), 1'b0);
      if (m_refill) check("model_mem_addr", mem_addr, m_pend);
      if (exp_hit)
        check("model_rdata", proc_rdata,
              m_data[int'(proc_addr[29:2] % NB)][32*int'(proc_addr[1:0]) +: 32]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a read that must miss, answers after lat REFILL cycles, returns observed stall/read counts.
  task automatic run_miss(input logic [29:0] a, input int lat, input logic [127:0] line,
                          output int n_stall, output int n_rd,
                          output logic [27:0] first_ma, output bit stable);
    n_stall  = 0;
    n_rd     = 0;
    first_ma = '0;
    stable   = 1'b1;
    proc_read = 1'b1;
    proc_addr = a;
    for (int c = 0; c <= lat; c++) begin
      mem_ready = (c == lat);
      mem_rdata = (c == lat) ? line : '0;
      @(negedge clk);
      if (proc_stall) n_stall++;
      if (mem_read) begin
        if (n_rd == 0) first_ma = mem_addr;
        else if (mem_addr !== first_ma) stable = 1'b0;
        n_rd++;
      end
      step();
    end
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic read_lit(input string name, input logic [29:0] a, input logic [31:0] exp);
    proc_read = 1'b1;
    proc_addr = a;
    @(negedge clk);
    check({name, "_stall"}, proc_stall, 1'b0);
    check({name, "_rdata"}, proc_rdata, exp);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ns, nr;
    logic [27:0] fma;
    bit          stab;

    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;

    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_stall", proc_stall, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_rdata", proc_rdata, 32'h0);
    step();
    rst_n = 1'b1;

    // Stray mem_ready in IDLE must not fill anything.
    mem_ready = 1'b1;
    mem_rdata = LBAD;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Cold miss to 0x4 then warm reads across the line.
    run_miss(30'h4, 2, L1, ns, nr, fma, stab);
    check("cold_stall_cycles", ns, 3);
    check("cold_read_cycles", nr, 2);
    check("cold_mem_addr", fma, 28'h1);
    read_lit("warm4", 30'h4, 32'h11111111);
    read_lit("warm5", 30'h5, 32'h22222222);
    read_lit("warm6", 30'h6, 32'h33333333);
    read_lit("warm7", 30'h7, 32'h44444444);

    // Writes are ignored.
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h5;
    proc_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_mem_write", mem_write, 1'b0);
    check("wr_stall", proc_stall, 1'b0);
    step();
    read_lit("wr_rd_both", 30'h5, 32'h22222222);
    proc_write = 1'b0;
    read_lit("wr_after", 30'h5, 32'h22222222);

    // Conflict on set 1: 0x24 evicts 0x4, then 0x4 misses again.
    run_miss(30'h24, 1, L9, ns, nr, fma, stab);
    check("conf_mem_addr", fma, 28'h9);
    check("conf_stall_cycles", ns, 2);
    read_lit("conf_hit24", 30'h24, 32'h99999990);
    run_miss(30'h4, 2, L1, ns, nr, fma, stab);
    check("conf_remiss_stall", ns, 3);
    check("conf_remiss_addr", fma, 28'h1);

    // Ten-cycle memory latency.
    run_miss(30'h13, 10, L4, ns, nr, fma, stab);
    check("lat10_stall_cycles", ns, 11);
    check("lat10_read_cycles", nr, 10);
    check("lat10_addr_stable", stab, 1'b1);
    check("lat10_mem_addr", fma, 28'h4);
    read_lit("lat10_hit", 30'h13, 32'hAAAA0003);

    // Address changes mid-refill: the latched line still fills.
    proc_read = 1'b1;
    proc_addr = 30'h30;
    step();
    proc_addr = 30'h8;
    @(negedge clk);
    check("chg_mem_addr", mem_addr, 28'hC);
    step();
    mem_ready = 1'b1;
    mem_rdata = LC;
    @(negedge clk);
    check("chg_mem_read", mem_read, 1'b1);
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("chg_new_addr_miss", proc_stall, 1'b1);
    #1 proc_read = 1'b0;
    step();
    read_lit("chg_hit30", 30'h30, 32'hCCCC0000);

    // Reset in the middle of a refill.
    proc_addr = 30'h8;
    step();
    @(negedge clk);
    check("rstmid_mem_read_before", mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_mem_read_async", mem_read, 1'b0);
    check("rstmid_mem_addr", mem_addr, 28'h0);
    proc_read = 1'b0;
    step();
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = LBAD;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("rstmid_idle_stall", proc_stall, 1'b0);
    step();
    run_miss(30'h4, 1, L1, ns, nr, fma, stab);
    check("rstmid_remiss_stall", ns, 2);
    read_lit("rstmid_hit", 30'h6, 32'h33333333);

    proc_read = 1'b0;
    repeat (3) step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
